// File: rtl/sfifo_pkg.sv
// Shared types and parameter checks for the parametrised synchronous FIFO.
// Imported by sfifo_mem and sync_fifo_param.
package sfifo_pkg;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } sfifo_status_t;

  // DEPTH must be a power of two (pointer wrap relies on it); thresholds lie in 0..DEPTH.
  function automatic bit sfifo_params_ok(input int depth, input int afull_th,
                                         input int aempty_th);
    bit ok;
    ok = (depth >= 2) && ((depth & (depth - 1)) == 0);
    ok = ok && (afull_th >= 0) && (afull_th <= depth);
    ok = ok && (aempty_th >= 0) && (aempty_th <= depth);
    return ok;
  endfunction

endpackage

// File: rtl/sfifo_mem.sv
// FIFO storage: DEPTH x DATA_W array with one synchronous write port and one
// asynchronous read port.
module sfifo_mem
  import sfifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [DATA_W-1:0]        i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [DATA_W-1:0]        o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with count, almost-full/empty thresholds and sticky
// overflow/underflow flags. Define SFIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_param
  import sfifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4,
  parameter int AFULL_TH  = DEPTH - 1,
  parameter int AEMPTY_TH = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_wr_en,
  input  logic [DATA_W-1:0]      i_wr_data,
  input  logic                   i_rd_en,
  input  logic                   i_err_clr,
  output logic [DATA_W-1:0]      o_rd_data,
  output logic                   o_rd_valid,
  output logic                   o_full,
  output logic                   o_empty,
  output logic                   o_almost_full,
  output logic                   o_almost_empty,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_overflow,
  output logic                   o_underflow
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LP_DEPTH  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LP_AFULL  = CNT_W'(AFULL_TH);
  localparam logic [CNT_W-1:0] LP_AEMPTY = CNT_W'(AEMPTY_TH);

  if (!sfifo_params_ok(DEPTH, AFULL_TH, AEMPTY_TH)) begin : g_param_err
    $error("sync_fifo_param: illegal DEPTH/AFULL_TH/AEMPTY_TH combination");
  end

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_overflow;
  logic              r_underflow;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic [DATA_W-1:0] w_mem_rdata;
  sfifo_status_t     w_status;

  always_comb begin
    w_status              = '0;
    w_status.full         = (r_count == LP_DEPTH);
    w_status.empty        = (r_count == '0);
    w_status.almost_full  = (r_count >= LP_AFULL);
    w_status.almost_empty = (r_count <= LP_AEMPTY);
    w_status.overflow     = r_overflow;
    w_status.underflow    = r_underflow;
  end

  // Requests are gated by rst so storage is not written during the reset cycle.
  assign w_wr_acc = !rst && i_wr_en && !w_status.full;
  assign w_rd_acc = !rst && i_rd_en && !w_status.empty;

  sfifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr),
    .i_wdata (i_wr_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A new error outranks err_clr in the same cycle so no event is ever lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (i_wr_en && w_status.full) r_overflow <= 1'b1;
      else if (i_err_clr)           r_overflow <= 1'b0;
      if (i_rd_en && w_status.empty) r_underflow <= 1'b1;
      else if (i_err_clr)            r_underflow <= 1'b0;
    end
  end

`ifdef SFIFO_FWFT_EN
  // Head word is shown directly; forced to zero while empty so stale storage never leaks out.
  assign o_rd_data  = w_status.empty ? '0 : w_mem_rdata;
  assign o_rd_valid = !w_status.empty;
`else
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) r_rd_data <= w_mem_rdata;
    end
  end

  assign o_rd_data  = r_rd_data;
  assign o_rd_valid = r_rd_valid;
`endif

  assign o_full         = w_status.full;
  assign o_empty        = w_status.empty;
  assign o_almost_full  = w_status.almost_full;
  assign o_almost_empty = w_status.almost_empty;
  assign o_count        = r_count;
  assign o_overflow     = w_status.overflow;
  assign o_underflow    = w_status.underflow;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed testbench for sync_fifo_param: a DEPTH=4 instance for data/flag behaviour and
// a DEPTH=16 instance for threshold decoding. Works in both read modes.
module tb_sync_fifo_param;

  logic       clk;
  logic       rst;
  logic       wrEn;
  logic [7:0] wrData;
  logic       rdEn;
  logic       errClr;
  logic [7:0] rdData;
  logic       rdValid;
  logic       full;
  logic       empty;
  logic       aFull;
  logic       aEmpty;
  logic [2:0] count;
  logic       overflow;
  logic       underflow;

  logic       wrEn16;
  logic [7:0] wrData16;
  logic       rdEn16;
  logic       errClr16;
  logic [7:0] rdData16;
  logic       rdValid16;
  logic       full16;
  logic       empty16;
  logic       aFull16;
  logic       aEmpty16;
  logic [4:0] count16;
  logic       overflow16;
  logic       underflow16;

  int compared;
  int mismatched;

  sync_fifo_param #(.DATA_W(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .i_wr_en(wrEn), .i_wr_data(wrData), .i_rd_en(rdEn),
    .i_err_clr(errClr), .o_rd_data(rdData), .o_rd_valid(rdValid), .o_full(full),
    .o_empty(empty), .o_almost_full(aFull), .o_almost_empty(aEmpty), .o_count(count),
    .o_overflow(overflow), .o_underflow(underflow)
  );

  sync_fifo_param #(.DATA_W(8), .DEPTH(16), .AFULL_TH(12), .AEMPTY_TH(3)) dut16 (
    .clk(clk), .rst(rst), .i_wr_en(wrEn16), .i_wr_data(wrData16), .i_rd_en(rdEn16),
    .i_err_clr(errClr16), .o_rd_data(rdData16), .o_rd_valid(rdValid16), .o_full(full16),
    .o_empty(empty16), .o_almost_full(aFull16), .o_almost_empty(aEmpty16), .o_count(count16),
    .o_overflow(overflow16), .o_underflow(underflow16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are observed 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pop one word and return what the reader sees for that pop in the active read mode.
  task automatic doPop(output logic [7:0] data, output logic valid);
    rdEn = 1'b1;
`ifdef SFIFO_FWFT_EN
    data  = rdData;
    valid = rdValid;
    tick();
`else
    tick();
    data  = rdData;
    valid = rdValid;
`endif
    rdEn = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; wrEn = 1'b0; rdEn = 1'b0; errClr = 1'b0; wrData = 8'h00;
    wrEn16 = 1'b0; rdEn16 = 1'b0; errClr16 = 1'b0; wrData16 = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    compared += 9;
    if (count !== 3'd0)     begin mismatched++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
    if (empty !== 1'b1)     begin mismatched++; $display("[TB] FAIL reset_empty: got %b expected 1", empty); end
    if (full !== 1'b0)      begin mismatched++; $display("[TB] FAIL reset_full: got %b expected 0", full); end
    if (aEmpty !== 1'b1)    begin mismatched++; $display("[TB] FAIL reset_aempty: got %b expected 1", aEmpty); end
    if (aFull !== 1'b0)     begin mismatched++; $display("[TB] FAIL reset_afull: got %b expected 0", aFull); end
    if (overflow !== 1'b0)  begin mismatched++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
    if (underflow !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_underflow: got %b expected 0", underflow); end
    if (rdValid !== 1'b0)   begin mismatched++; $display("[TB] FAIL reset_rdvalid: got %b expected 0", rdValid); end
    if (rdData !== 8'h00)   begin mismatched++; $display("[TB] FAIL reset_rddata: got %h expected 00", rdData); end
  endtask

  task automatic test_fill_drain();
    logic [7:0] vals [4];
    logic [7:0] obs;
    logic       v;
    vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      wrEn = 1'b1; wrData = vals[i];
      tick();
    end
    wrEn = 1'b0;
    compared += 3;
    if (full !== 1'b1)   begin mismatched++; $display("[TB] FAIL fill_full: got %b expected 1", full); end
    if (count !== 3'd4)  begin mismatched++; $display("[TB] FAIL fill_count: got %0d expected 4", count); end
    if (aFull !== 1'b1)  begin mismatched++; $display("[TB] FAIL fill_afull: got %b expected 1", aFull); end
    for (int i = 0; i < 4; i++) begin
      doPop(obs, v);
      compared += 2;
      if (obs !== vals[i]) begin mismatched++; $display("[TB] FAIL drain_data[%0d]: got %h expected %h", i, obs, vals[i]); end
      if (v !== 1'b1)      begin mismatched++; $display("[TB] FAIL drain_valid[%0d]: got %b expected 1", i, v); end
    end
    compared += 2;
    if (empty !== 1'b1) begin mismatched++; $display("[TB] FAIL drain_empty: got %b expected 1", empty); end
    if (count !== 3'd0) begin mismatched++; $display("[TB] FAIL drain_count: got %0d expected 0", count); end
    tick();
    compared += 1;
    if (rdValid !== 1'b0) begin mismatched++; $display("[TB] FAIL idle_rdvalid: got %b expected 0", rdValid); end
`ifndef SFIFO_FWFT_EN
    compared += 1;
    if (rdData !== 8'h44) begin mismatched++; $display("[TB] FAIL hold_rddata: got %h expected 44", rdData); end
`endif
  endtask

  task automatic test_overflow();
    logic [7:0] vals [4];
    logic [7:0] obs;
    logic       v;
    vals = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    for (int i = 0; i < 4; i++) begin
      wrEn = 1'b1; wrData = vals[i];
      tick();
    end
    wrData = 8'h55;
    tick();
    wrEn = 1'b0;
    compared += 2;
    if (count !== 3'd4)     begin mismatched++; $display("[TB] FAIL ovf_count: got %0d expected 4", count); end
    if (overflow !== 1'b1)  begin mismatched++; $display("[TB] FAIL ovf_set: got %b expected 1", overflow); end
    errClr = 1'b1;
    tick();
    errClr = 1'b0;
    compared += 1;
    if (overflow !== 1'b0)  begin mismatched++; $display("[TB] FAIL ovf_clear: got %b expected 0", overflow); end
    // read+write while full: only the read is accepted
    rdEn = 1'b1; wrEn = 1'b1; wrData = 8'h77;
`ifdef SFIFO_FWFT_EN
    obs = rdData;
    tick();
`else
    tick();
    obs = rdData;
`endif
    rdEn = 1'b0; wrEn = 1'b0;
    compared += 3;
    if (obs !== 8'hA1)     begin mismatched++; $display("[TB] FAIL fullrw_data: got %h expected a1", obs); end
    if (count !== 3'd3)    begin mismatched++; $display("[TB] FAIL fullrw_count: got %0d expected 3", count); end
    if (overflow !== 1'b1) begin mismatched++; $display("[TB] FAIL fullrw_overflow: got %b expected 1", overflow); end
    for (int i = 1; i < 4; i++) begin
      doPop(obs, v);
      compared += 1;
      if (obs !== vals[i]) begin mismatched++; $display("[TB] FAIL ovf_drain[%0d]: got %h expected %h", i, obs, vals[i]); end
    end
    compared += 1;
    if (empty !== 1'b1) begin mismatched++; $display("[TB] FAIL ovf_empty: got %b expected 1", empty); end
    errClr = 1'b1;
    tick();
    errClr = 1'b0;
  endtask

  task automatic test_underflow();
    logic [7:0] obs;
    logic       v;
    rdEn = 1'b1;
    tick();
    rdEn = 1'b0;
    compared += 3;
    if (underflow !== 1'b1) begin mismatched++; $display("[TB] FAIL udf_set: got %b expected 1", underflow); end
    if (rdValid !== 1'b0)   begin mismatched++; $display("[TB] FAIL udf_rdvalid: got %b expected 0", rdValid); end
    if (count !== 3'd0)     begin mismatched++; $display("[TB] FAIL udf_count: got %0d expected 0", count); end
    errClr = 1'b1;
    tick();
    errClr = 1'b0;
    compared += 1;
    if (underflow !== 1'b0) begin mismatched++; $display("[TB] FAIL udf_clear: got %b expected 0", underflow); end
    rdEn = 1'b1; wrEn = 1'b1; wrData = 8'h66;
    tick();
    rdEn = 1'b0; wrEn = 1'b0;
    compared += 2;
    if (count !== 3'd1)     begin mismatched++; $display("[TB] FAIL emptyrw_count: got %0d expected 1", count); end
    if (underflow !== 1'b1) begin mismatched++; $display("[TB] FAIL emptyrw_underflow: got %b expected 1", underflow); end
    doPop(obs, v);
    compared += 1;
    if (obs !== 8'h66) begin mismatched++; $display("[TB] FAIL emptyrw_data: got %h expected 66", obs); end
    // new underflow coincident with err_clr must keep the flag set
    rdEn = 1'b1; errClr = 1'b1;
    tick();
    rdEn = 1'b0;
    compared += 1;
    if (underflow !== 1'b1) begin mismatched++; $display("[TB] FAIL udf_setwins: got %b expected 1", underflow); end
    tick();
    errClr = 1'b0;
    compared += 1;
    if (underflow !== 1'b0) begin mismatched++; $display("[TB] FAIL udf_clear2: got %b expected 0", underflow); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] obs;
    logic       v;
    for (int i = 0; i < 2; i++) begin
      wrEn = 1'b1; wrData = 8'(i + 1);
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      wrEn = 1'b1; rdEn = 1'b1; wrData = 8'(i + 3);
`ifdef SFIFO_FWFT_EN
      obs = rdData;
      tick();
`else
      tick();
      obs = rdData;
`endif
      compared += 2;
      if (obs !== 8'(i + 1)) begin mismatched++; $display("[TB] FAIL b2b_data[%0d]: got %h expected %h", i, obs, 8'(i + 1)); end
      if (count !== 3'd2)    begin mismatched++; $display("[TB] FAIL b2b_count[%0d]: got %0d expected 2", i, count); end
    end
    wrEn = 1'b0; rdEn = 1'b0;
    doPop(obs, v);
    compared += 1;
    if (obs !== 8'h0B) begin mismatched++; $display("[TB] FAIL b2b_tail0: got %h expected 0b", obs); end
    doPop(obs, v);
    compared += 2;
    if (obs !== 8'h0C)  begin mismatched++; $display("[TB] FAIL b2b_tail1: got %h expected 0c", obs); end
    if (empty !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_empty: got %b expected 1", empty); end
  endtask

  task automatic test_thresholds();
    logic expAE;
    logic expAF;
    compared += 2;
    if (aEmpty16 !== 1'b1) begin mismatched++; $display("[TB] FAIL th_aempty0: got %b expected 1", aEmpty16); end
    if (aFull16 !== 1'b0)  begin mismatched++; $display("[TB] FAIL th_afull0: got %b expected 0", aFull16); end
    for (int k = 1; k <= 16; k++) begin
      wrEn16 = 1'b1; wrData16 = 8'(k);
      tick();
      expAE = (k <= 3);
      expAF = (k >= 12);
      compared += 3;
      if (count16 !== 5'(k))  begin mismatched++; $display("[TB] FAIL th_count[%0d]: got %0d expected %0d", k, count16, k); end
      if (aEmpty16 !== expAE) begin mismatched++; $display("[TB] FAIL th_aempty[%0d]: got %b expected %b", k, aEmpty16, expAE); end
      if (aFull16 !== expAF)  begin mismatched++; $display("[TB] FAIL th_afull[%0d]: got %b expected %b", k, aFull16, expAF); end
    end
    wrEn16 = 1'b0;
    compared += 1;
    if (full16 !== 1'b1) begin mismatched++; $display("[TB] FAIL th_full: got %b expected 1", full16); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] obs;
    logic       v;
    rdEn = 1'b1;
    tick();
    rdEn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wrEn = 1'b1; wrData = 8'(8'hB1 + i);
      tick();
    end
    compared += 1;
    if (count !== 3'd3) begin mismatched++; $display("[TB] FAIL mid_precount: got %0d expected 3", count); end
    rst = 1'b1; wrData = 8'hEE;
    tick();
    rst = 1'b0; wrEn = 1'b0;
    compared += 5;
    if (count !== 3'd0)     begin mismatched++; $display("[TB] FAIL mid_count: got %0d expected 0", count); end
    if (empty !== 1'b1)     begin mismatched++; $display("[TB] FAIL mid_empty: got %b expected 1", empty); end
    if (underflow !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_underflow: got %b expected 0", underflow); end
    if (overflow !== 1'b0)  begin mismatched++; $display("[TB] FAIL mid_overflow: got %b expected 0", overflow); end
    if (rdValid !== 1'b0)   begin mismatched++; $display("[TB] FAIL mid_rdvalid: got %b expected 0", rdValid); end
    wrEn = 1'b1; wrData = 8'hA5;
    tick();
    wrEn = 1'b0;
    compared += 1;
    if (count !== 3'd1) begin mismatched++; $display("[TB] FAIL post_count: got %0d expected 1", count); end
    doPop(obs, v);
    compared += 2;
    if (obs !== 8'hA5) begin mismatched++; $display("[TB] FAIL post_data: got %h expected a5", obs); end
    if (v !== 1'b1)    begin mismatched++; $display("[TB] FAIL post_valid: got %b expected 1", v); end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_back_to_back();
    test_thresholds();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
